// File: rtl/piano_pkg.sv
// Shared constants for the piano tone generator: FSM encodings, note indices
// and the octave-0 half-period table in 25 MHz clock cycles.
package piano_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_HIGH = 2'd1;
   localparam state_t ST_LOW  = 2'd2;

   localparam logic [2:0] NOTE_C  = 3'd0;
   localparam logic [2:0] NOTE_D  = 3'd1;
   localparam logic [2:0] NOTE_E  = 3'd2;
   localparam logic [2:0] NOTE_F  = 3'd3;
   localparam logic [2:0] NOTE_G  = 3'd4;
   localparam logic [2:0] NOTE_A  = 3'd5;
   localparam logic [2:0] NOTE_B  = 3'd6;
   localparam logic [2:0] NOTE_C5 = 3'd7;

   localparam logic [15:0] HALF_PERIOD [0:7] = '{
      16'd47778, 16'd42566, 16'd37922, 16'd35793,
      16'd31888, 16'd28409, 16'd25310, 16'd23889
   };

endpackage

// File: rtl/piano_half_period_lut.sv
// Combinational note/octave to half-period lookup; a shifted result of zero
// is clamped to one so the FSM never sees an empty phase.
module piano_half_period_lut
   import piano_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int OCT_W = 2
) (
   input  logic [2:0]       note_sel_i,
   input  logic [OCT_W-1:0] octave_i,
   output logic [CNT_W-1:0] half_o
);

   logic [15:0]      base_s;
   logic [CNT_W-1:0] shifted_s;

   // Select the octave-0 half period for the requested note.
   always_comb begin
      case (note_sel_i)
         NOTE_C:  base_s = HALF_PERIOD[0];
         NOTE_D:  base_s = HALF_PERIOD[1];
         NOTE_E:  base_s = HALF_PERIOD[2];
         NOTE_F:  base_s = HALF_PERIOD[3];
         NOTE_G:  base_s = HALF_PERIOD[4];
         NOTE_A:  base_s = HALF_PERIOD[5];
         NOTE_B:  base_s = HALF_PERIOD[6];
         NOTE_C5: base_s = HALF_PERIOD[7];
         default: base_s = HALF_PERIOD[0];
      endcase
   end

   // Octave shift with clamp to a minimum of one cycle.
   always_comb begin
      shifted_s = CNT_W'(base_s) >> octave_i;
      if (shifted_s == {CNT_W{1'b0}}) begin
         half_o = CNT_W'(1);
      end else begin
         half_o = shifted_s;
      end
   end

endmodule

// File: rtl/piano_tone_gen.sv
// 50% duty square-wave note generator; pitch is latched only at period boundaries.
// Optional sustain limit enabled by defining SUSTAIN_LIMIT_EN.
module piano_tone_gen
   import piano_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int OCT_W       = 2,
   parameter int MAX_PERIODS = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_on,
   input  logic [2:0]       note_sel,
   input  logic [OCT_W-1:0] octave,
   output logic             speaker,
   output logic             busy,
   output logic             period_tick,
   output logic [2:0]       cur_note,
   output logic             timeout
);

   if (CNT_W < 16 || MAX_PERIODS < 1) begin : g_param_check
      $error("piano_tone_gen: CNT_W must be >= 16 and MAX_PERIODS >= 1");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [2:0]       note_q, note_d;
   logic [CNT_W-1:0] lut_half_s;
   logic             last_s;
   logic             limit_s;
   logic             lock_s;

   piano_half_period_lut #(
      .CNT_W (CNT_W),
      .OCT_W (OCT_W)
   ) u_lut (
      .note_sel_i (note_sel),
      .octave_i   (octave),
      .half_o     (lut_half_s)
   );

   assign last_s = (cnt_q == (half_q - CNT_W'(1)));

`ifdef SUSTAIN_LIMIT_EN
   localparam int PCNT_W = $clog2(MAX_PERIODS + 1);
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic              timeout_q, timeout_d;

   assign limit_s = ((pcnt_q + PCNT_W'(1)) == PCNT_W'(MAX_PERIODS));
   assign lock_s  = timeout_q;
   assign timeout = timeout_q;
`else
   assign limit_s = 1'b0;
   assign lock_s  = 1'b0;
   assign timeout = 1'b0;
`endif

   // Next-state logic for the IDLE/HIGH/LOW sequencer and its counters.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      note_d  = note_q;
`ifdef SUSTAIN_LIMIT_EN
      pcnt_d  = pcnt_q;
      if (timeout_q && !key_on) begin
         timeout_d = 1'b0;
      end else begin
         timeout_d = timeout_q;
      end
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (key_on && !lock_s) begin
               state_d = ST_HIGH;
               half_d  = lut_half_s;
               note_d  = note_sel;
`ifdef SUSTAIN_LIMIT_EN
               pcnt_d  = {PCNT_W{1'b0}};
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (last_s) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_LOW;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_LOW: begin
            if (last_s) begin
               cnt_d = {CNT_W{1'b0}};
`ifdef SUSTAIN_LIMIT_EN
               pcnt_d = pcnt_q + PCNT_W'(1);
`endif
               // Sustain limit wins over a held key; otherwise re-latch pitch here.
               if (limit_s) begin
                  state_d = ST_IDLE;
`ifdef SUSTAIN_LIMIT_EN
                  timeout_d = 1'b1;
`endif
               end else if (key_on) begin
                  state_d = ST_HIGH;
                  half_d  = lut_half_s;
                  note_d  = note_sel;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         half_q    <= {CNT_W{1'b0}};
         note_q    <= 3'd0;
`ifdef SUSTAIN_LIMIT_EN
         pcnt_q    <= {PCNT_W{1'b0}};
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         note_q    <= note_d;
`ifdef SUSTAIN_LIMIT_EN
         pcnt_q    <= pcnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign speaker     = (state_q == ST_HIGH);
   assign busy        = (state_q == ST_HIGH) || (state_q == ST_LOW);
   assign period_tick = (state_q == ST_LOW) && last_s;
   assign cur_note    = note_q;

endmodule
